// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: bus widths, slave limits, stall FSM states and
// a byte-lane merge helper that other register slaves reuse.
package wb_pkg;

  localparam int WB_DATA_WIDTH      = 32;
  localparam int WB_SEL_WIDTH       = 4;
  localparam int WB_MAX_ACK_LATENCY = 4;
  localparam int WB_MAX_WAIT_STATES = 15;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } stall_state_t;

  // Each sel bit chooses the new byte over the old one for its lane.
  function automatic logic [WB_DATA_WIDTH-1:0] wb_byte_merge(
    input logic [WB_DATA_WIDTH-1:0] old_word,
    input logic [WB_DATA_WIDTH-1:0] new_word,
    input logic [WB_SEL_WIDTH-1:0]  sel
  );
    logic [WB_DATA_WIDTH-1:0] merged;
    merged = old_word;
    for (int i = 0; i < WB_SEL_WIDTH; i++) begin
      if (sel[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/wb_ack_pipe.sv
// Fixed-depth response pipeline carrying {ack, err, data}; flush empties every
// stage on the same edge so no response escapes once the bus cycle is abandoned.
module wb_ack_pipe #(
  parameter int DEPTH = 1,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_ack,
  input  logic          in_err,
  input  logic [DW-1:0] in_data,
  output logic          out_ack,
  output logic          out_err,
  output logic [DW-1:0] out_data
);

  logic [DEPTH-1:0] ack_sr;
  logic [DEPTH-1:0] err_sr;
  logic [DW-1:0]    data_sr [DEPTH];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ack_sr <= '0;
      err_sr <= '0;
      for (int i = 0; i < DEPTH; i++) data_sr[i] <= '0;
    end else begin
      ack_sr[0]  <= in_ack;
      err_sr[0]  <= in_err;
      data_sr[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        ack_sr[i]  <= ack_sr[i-1];
        err_sr[i]  <= err_sr[i-1];
        data_sr[i] <= data_sr[i-1];
      end
    end
  end

  assign out_ack  = ack_sr[DEPTH-1];
  assign out_err  = err_sr[DEPTH-1];
  assign out_data = data_sr[DEPTH-1];

endmodule

// File: rtl/wb_regs_slave.sv
// Wishbone B4 pipelined slave exposing NREGS 32-bit registers with optional
// wait states and fixed ack latency. Define WB_REGS_SLAVE_ERR_EN for o_wb_err.
module wb_regs_slave
  import wb_pkg::*;
#(
  parameter int WB_ADDR_WIDTH = 30,
  parameter int NREGS         = 16,
  parameter int WAIT_STATES   = 0,
  parameter int ACK_LATENCY   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wb_cyc,
  input  logic                     i_wb_stb,
  output logic                     o_wb_stall,
  output logic                     o_wb_ack,
  input  logic                     i_wb_we,
  input  logic [WB_ADDR_WIDTH-1:0] i_wb_addr,
  input  logic [31:0]              i_wb_data,
  input  logic [3:0]               i_wb_sel,
  output logic [31:0]              o_wb_data,
`ifdef WB_REGS_SLAVE_ERR_EN
  output logic                     o_wb_err,
`endif
  output logic [32*NREGS-1:0]      o_regs
);

  localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int AXW   = (WB_ADDR_WIDTH > 32) ? WB_ADDR_WIDTH : 32;

  logic [31:0]      regs [NREGS];
  logic [AXW-1:0]   addr_ext;
  logic [IDX_W-1:0] reg_idx;
  logic             in_range;
  logic             accept;
  logic [31:0]      rd_data;

  stall_state_t state, state_nxt;
  logic [3:0]   wait_cnt, wait_cnt_nxt;

  logic        pipe_in_ack;
  logic        pipe_in_err;
  logic        pipe_ack;
  logic        pipe_err;
  logic [31:0] pipe_data;

  // Full address width takes part in the range check, so no aliasing above NREGS.
  assign addr_ext = AXW'(i_wb_addr);
  assign in_range = addr_ext < AXW'(NREGS);
  assign reg_idx  = addr_ext[IDX_W-1:0];

  assign o_wb_stall = (state == ST_WAIT) && i_wb_cyc;
  assign accept     = i_wb_cyc && i_wb_stb && !o_wb_stall;
  assign rd_data    = (accept && !i_wb_we && in_range) ? regs[reg_idx] : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREGS; k++) regs[k] <= '0;
    end else if (accept && i_wb_we && in_range) begin
      regs[reg_idx] <= wb_byte_merge(regs[reg_idx], i_wb_data, i_wb_sel);
    end
  end

  always_comb begin
    o_regs = '0;
    for (int k = 0; k < NREGS; k++) o_regs[32*k +: 32] = regs[k];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Dropping cyc abandons the cycle: any wait in progress is cancelled.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    if (!i_wb_cyc) begin
      state_nxt    = ST_IDLE;
      wait_cnt_nxt = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept && (WAIT_STATES > 0)) begin
            wait_cnt_nxt = 4'(WAIT_STATES);
            state_nxt    = ST_WAIT;
          end
        end
        ST_WAIT: begin
          wait_cnt_nxt = wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) state_nxt = ST_IDLE;
        end
        default: begin
          state_nxt    = ST_IDLE;
          wait_cnt_nxt = '0;
        end
      endcase
    end
  end

`ifdef WB_REGS_SLAVE_ERR_EN
  assign pipe_in_ack = accept && in_range;
  assign pipe_in_err = accept && !in_range;
`else
  assign pipe_in_ack = accept;
  assign pipe_in_err = 1'b0;
`endif

  wb_ack_pipe #(
    .DEPTH (ACK_LATENCY),
    .DW    (32)
  ) u_ack_pipe (
    .clk      (clk),
    .rst      (rst),
    .flush    (!i_wb_cyc),
    .in_ack   (pipe_in_ack),
    .in_err   (pipe_in_err),
    .in_data  (rd_data),
    .out_ack  (pipe_ack),
    .out_err  (pipe_err),
    .out_data (pipe_data)
  );

`ifdef WB_REGS_SLAVE_ERR_EN
  assign o_wb_ack  = pipe_ack && i_wb_cyc;
  assign o_wb_err  = pipe_err && i_wb_cyc;
`else
  // Without the err output every response is an ack; the err lane stays idle.
  assign o_wb_ack  = (pipe_ack || pipe_err) && i_wb_cyc;
`endif
  assign o_wb_data = o_wb_ack ? pipe_data : 32'h0;

endmodule

// File: tb/tb_wb_regs_slave.sv
// Directed self-checking bench for wb_regs_slave: three instances cover
// single-cycle latency, pipelined latency and wait-state/abort behaviour.
module tb_wb_regs_slave;

  logic clk;
  logic rst;

  logic         cyc     [3];
  logic         stb     [3];
  logic         we      [3];
  logic [29:0]  addr    [3];
  logic [31:0]  wdata   [3];
  logic [3:0]   sel     [3];
  logic         stall   [3];
  logic         ack     [3];
  logic [31:0]  rdata   [3];
  logic [511:0] regs_v  [3];
`ifdef WB_REGS_SLAVE_ERR_EN
  logic         err     [3];
`endif

  int tests_run;
  int tests_failed;

  logic [511:0] exp_regs;
  logic         exp_stall_c [7];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: no waits, latency 1. Instance 1: no waits, latency 3.
  // Instance 2: two wait states, latency 4.
  wb_regs_slave #(.WB_ADDR_WIDTH(30), .NREGS(16), .WAIT_STATES(0), .ACK_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst), .i_wb_cyc(cyc[0]), .i_wb_stb(stb[0]), .o_wb_stall(stall[0]),
    .o_wb_ack(ack[0]), .i_wb_we(we[0]), .i_wb_addr(addr[0]), .i_wb_data(wdata[0]),
    .i_wb_sel(sel[0]), .o_wb_data(rdata[0]),
`ifdef WB_REGS_SLAVE_ERR_EN
    .o_wb_err(err[0]),
`endif
    .o_regs(regs_v[0]));

  wb_regs_slave #(.WB_ADDR_WIDTH(30), .NREGS(16), .WAIT_STATES(0), .ACK_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst), .i_wb_cyc(cyc[1]), .i_wb_stb(stb[1]), .o_wb_stall(stall[1]),
    .o_wb_ack(ack[1]), .i_wb_we(we[1]), .i_wb_addr(addr[1]), .i_wb_data(wdata[1]),
    .i_wb_sel(sel[1]), .o_wb_data(rdata[1]),
`ifdef WB_REGS_SLAVE_ERR_EN
    .o_wb_err(err[1]),
`endif
    .o_regs(regs_v[1]));

  wb_regs_slave #(.WB_ADDR_WIDTH(30), .NREGS(16), .WAIT_STATES(2), .ACK_LATENCY(4)) dut_c (
    .clk(clk), .rst(rst), .i_wb_cyc(cyc[2]), .i_wb_stb(stb[2]), .o_wb_stall(stall[2]),
    .o_wb_ack(ack[2]), .i_wb_we(we[2]), .i_wb_addr(addr[2]), .i_wb_data(wdata[2]),
    .i_wb_sel(sel[2]), .o_wb_data(rdata[2]),
`ifdef WB_REGS_SLAVE_ERR_EN
    .o_wb_err(err[2]),
`endif
    .o_regs(regs_v[2]));

  task automatic checkOutput(input string tag, input logic [511:0] got, input logic [511:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int d, input logic c, input logic s, input logic w,
                               input logic [29:0] a, input logic [31:0] dat, input logic [3:0] sl);
    cyc[d]   = c;
    stb[d]   = s;
    we[d]    = w;
    addr[d]  = a;
    wdata[d] = dat;
    sel[d]   = sl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response for a completed request: err for out-of-range when the feature is on, else ack.
  task automatic checkResp(input string tag, input int d, input bit oor, input logic [31:0] exp_data);
`ifdef WB_REGS_SLAVE_ERR_EN
    checkOutput({tag, "_ack"}, 512'(ack[d]), 512'(!oor));
    checkOutput({tag, "_err"}, 512'(err[d]), 512'(oor));
`else
    checkOutput({tag, "_ack"}, 512'(ack[d]), 512'(oor ? 1'b1 : 1'b1));
`endif
    checkOutput({tag, "_data"}, 512'(rdata[d]), 512'(exp_data));
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) applyStimulus(d, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    repeat (3) tick();
    #1;
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("reset_stall%0d", d), 512'(stall[d]), 512'd0);
      checkOutput($sformatf("reset_ack%0d", d), 512'(ack[d]), 512'd0);
      checkOutput($sformatf("reset_data%0d", d), 512'(rdata[d]), 512'd0);
      checkOutput($sformatf("reset_regs%0d", d), regs_v[d], 512'd0);
    end
    rst = 1'b0;

    // Write then read, latency 1.
    tick(); applyStimulus(0, 1, 1, 1, 30'd3, 32'hDEADBEEF, 4'hF); #1;
    checkOutput("a_wr_stall", 512'(stall[0]), 512'd0);
    checkOutput("a_wr_noack", 512'(ack[0]), 512'd0);
    tick(); applyStimulus(0, 1, 1, 0, 30'd3, 32'h0, 4'hF); #1;
    checkOutput("a_wr_ack", 512'(ack[0]), 512'd1);
    checkOutput("a_wr_data", 512'(rdata[0]), 512'd0);
    checkOutput("a_reg3", 512'(regs_v[0][127:96]), 512'hDEADBEEF);
    tick(); applyStimulus(0, 1, 0, 0, 30'd0, 32'h0, 4'h0); #1;
    checkOutput("a_rd_ack", 512'(ack[0]), 512'd1);
    checkOutput("a_rd_data", 512'(rdata[0]), 512'hDEADBEEF);
    tick(); #1;
    checkOutput("a_idle_ack", 512'(ack[0]), 512'd0);
    checkOutput("a_idle_data", 512'(rdata[0]), 512'd0);

    // Byte lanes, including a sel=0 write that must change nothing.
    tick(); applyStimulus(0, 1, 1, 1, 30'd5, 32'h11223344, 4'hF);
    tick(); applyStimulus(0, 1, 1, 1, 30'd5, 32'hAABBCCDD, 4'b0101);
    tick(); applyStimulus(0, 1, 1, 1, 30'd5, 32'hFFFFFFFF, 4'b0000); #1;
    checkOutput("a_sel0_ack", 512'(ack[0]), 512'd1);
    tick(); applyStimulus(0, 1, 1, 0, 30'd5, 32'h0, 4'h1); #1;
    checkOutput("a_sel0_reg5", 512'(regs_v[0][191:160]), 512'h11BB33DD);
    tick(); applyStimulus(0, 1, 0, 0, 30'd0, 32'h0, 4'h0); #1;
    checkOutput("a_lane_ack", 512'(ack[0]), 512'd1);
    checkOutput("a_lane_data", 512'(rdata[0]), 512'h11BB33DD);

    // Out of range: addr 16, and addr 21 which would alias reg 5 on 4 bits.
    exp_regs = '0;
    exp_regs[127:96]  = 32'hDEADBEEF;
    exp_regs[191:160] = 32'h11BB33DD;
    tick(); applyStimulus(0, 1, 1, 1, 30'd16, 32'hFFFFFFFF, 4'hF);
    tick(); applyStimulus(0, 1, 1, 0, 30'd16, 32'h0, 4'hF); #1;
    checkResp("a_oor_wr", 0, 1'b1, 32'h0);
    tick(); applyStimulus(0, 1, 1, 1, 30'd21, 32'h12345678, 4'hF); #1;
    checkResp("a_oor_rd", 0, 1'b1, 32'h0);
    tick(); applyStimulus(0, 1, 0, 0, 30'd0, 32'h0, 4'h0); #1;
    checkResp("a_oor_alias", 0, 1'b1, 32'h0);
    tick(); #1;
    checkOutput("a_oor_regs", regs_v[0], exp_regs);
    tick(); applyStimulus(0, 0, 0, 0, 30'd0, 32'h0, 4'h0);

    // Latency 3: writes then reads back-to-back, acks in order.
    for (int i = 0; i < 3; i++) begin
      tick(); applyStimulus(1, 1, 1, 1, 30'(i), 32'hA0 + 32'(i), 4'hF);
    end
    for (int i = 0; i < 3; i++) begin
      tick(); applyStimulus(1, 1, 1, 0, 30'(i), 32'h0, 4'hF); #1;
      checkOutput($sformatf("b_wack%0d", i), 512'(ack[1]), 512'd1);
      checkOutput($sformatf("b_stall_rd%0d", i), 512'(stall[1]), 512'd0);
    end
    for (int i = 0; i < 3; i++) begin
      tick(); applyStimulus(1, 1, 0, 0, 30'd0, 32'h0, 4'h0); #1;
      checkOutput($sformatf("b_rack%0d", i), 512'(ack[1]), 512'd1);
      checkOutput($sformatf("b_rdata%0d", i), 512'(rdata[1]), 512'hA0 + 512'(i));
    end
    tick(); #1;
    checkOutput("b_drain", 512'(ack[1]), 512'd0);

    // Abort: read, write, then cyc drops before either ack arrives.
    tick(); applyStimulus(1, 1, 1, 0, 30'd1, 32'h0, 4'hF);
    tick(); applyStimulus(1, 1, 1, 1, 30'd3, 32'h33, 4'hF);
    tick(); applyStimulus(1, 0, 0, 0, 30'd0, 32'h0, 4'h0); #1;
    checkOutput("b_abort_u2", 512'(ack[1]), 512'd0);
    tick(); applyStimulus(1, 1, 0, 0, 30'd0, 32'h0, 4'h0); #1;
    checkOutput("b_abort_u3", 512'(ack[1]), 512'd0);
    tick(); #1;
    checkOutput("b_abort_u4", 512'(ack[1]), 512'd0);
    checkOutput("b_abort_reg3", 512'(regs_v[1][127:96]), 512'h33);
    tick(); applyStimulus(1, 0, 0, 0, 30'd0, 32'h0, 4'h0);

    // Two wait states with stb held: accepts at t0, t3, t6.
    exp_stall_c = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int t = 0; t < 7; t++) begin
      tick();
      if (t == 0) applyStimulus(2, 1, 1, 0, 30'd0, 32'h0, 4'hF);
      #1;
      checkOutput($sformatf("c_stall_t%0d", t), 512'(stall[2]), 512'(exp_stall_c[t]));
      checkOutput($sformatf("c_ack_t%0d", t), 512'(ack[2]), 512'(t == 4));
    end
    tick(); applyStimulus(2, 1, 0, 0, 30'd0, 32'h0, 4'h0); #1;
    checkOutput("c_ack_t7", 512'(ack[2]), 512'd1);
    checkOutput("c_stall_t7", 512'(stall[2]), 512'd1);
    tick(); applyStimulus(2, 0, 0, 0, 30'd0, 32'h0, 4'h0); #1;
    checkOutput("c_cyclow_stall", 512'(stall[2]), 512'd0);
    checkOutput("c_cyclow_ack", 512'(ack[2]), 512'd0);
    tick(); applyStimulus(2, 1, 0, 0, 30'd0, 32'h0, 4'h0); #1;
    checkOutput("c_recyc_stall", 512'(stall[2]), 512'd0);
    tick(); #1;
    checkOutput("c_flushed_ack", 512'(ack[2]), 512'd0);
    tick(); applyStimulus(2, 0, 0, 0, 30'd0, 32'h0, 4'h0);

    // Reset while a latency-3 read is in flight.
    tick(); applyStimulus(1, 1, 1, 0, 30'd3, 32'h0, 4'hF);
    tick(); applyStimulus(1, 1, 0, 0, 30'd0, 32'h0, 4'h0); rst = 1'b1;
    tick(); rst = 1'b0; #1;
    checkOutput("rst_mid_ack_r2", 512'(ack[1]), 512'd0);
    checkOutput("rst_mid_regs", regs_v[1], 512'd0);
    tick(); #1;
    checkOutput("rst_mid_ack_r3", 512'(ack[1]), 512'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
